pwm_dac: RTL and testbench
==========================

Name: pwm_dac

Overview:
- Output stage directly downstream of the waveform selector.
- Consumes the selected 12-bit waveform sample, applies a 4-bit volume scale, and drives a 1-bit PWM output for an external RC filter.
- Emits a one-cycle sample strobe at each PWM period boundary so upstream generators can advance in lock-step.

Parameters:
- WIDTH, 12, sample width and PWM counter width; PWM period = 2^WIDTH clocks.
- VOL_W, 4, volume control width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; low parks the block.
- wave  input  WIDTH  selected waveform sample, unsigned.
- volume  input  VOL_W  amplitude scale, 15 = unity.
- pwm_out  output  1  registered PWM output.
- sample_tick  output  1  one-cycle pulse; new period and new duty start.
- duty  output  WIDTH  currently active scaled duty value (debug/observability).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - cnt = 2^WIDTH-1 (all ones).
  - duty = 0, pwm_out = 0, sample_tick = 0.
- Scale rule:
  - scaled = (wave * (volume+1)) >> VOL_W.
  - Full-width product of WIDTH+VOL_W bits, then truncate. No rounding.
  - volume = 15 gives scaled = wave. volume = 0 gives wave >> 4.
- Rising edge with en = 1 and cnt = all ones (wrap):
  - cnt <= 0.
  - duty <= scaled, using wave and volume as seen this cycle.
  - sample_tick <= 1.
  - pwm_out <= (scaled != 0).
- Rising edge with en = 1, other cnt values:
  - cnt <= cnt+1.
  - sample_tick <= 0.
  - pwm_out <= ((cnt+1) < duty).
- Resulting waveform:
  - In each period pwm_out is high for exactly duty clocks, starting in the cycle sample_tick is high, then low for 2^WIDTH - duty clocks.
  - duty = 0: pwm_out constantly low.
  - duty = 4095: high 4095, low 1; 100% duty is unreachable by design.
- wave and volume are sampled only at the wrap edge. Changes mid-period have no effect until the next sample_tick.
- en = 0 at a rising edge:
  - cnt <= all ones, pwm_out <= 0, sample_tick <= 0.
  - duty holds its value.
  - The first edge with en = 1 is a wrap edge: sample_tick pulses and a new duty is latched immediately.
- Async rst mid-period:
  - All state returns to reset values immediately, no clock required.
  - After release, the first enabled edge is a wrap edge.
- sample_tick is high exactly 1 cycle per 2^WIDTH cycles while en stays high; never two consecutive cycles.
- Latency:
  - wave to duty: up to 2^WIDTH clocks (next boundary).
  - duty to pwm_out: 0 additional clocks; new duty is effective in the tick cycle.

Test Plan:
- Reset/start: assert rst mid-run → pwm_out = 0, sample_tick = 0, duty = 0 without a clock edge. Release with en = 1, wave = 0x800, volume = 15 → sample_tick high on first edge, duty = 0x800.
- Midscale: wave = 0x800, volume = 15, run 3 periods → pwm_out high exactly 2048 then low 2048 clocks per period; sample_tick spacing exactly 4096 clocks.
- Extremes: wave = 0xFFF, volume = 15 → duty = 4095, pwm_out high 4095 and low 1 per period. wave = 0x000 → pwm_out never high, sample_tick still every 4096 clocks.
- Scaling: wave = 0xFFF with volume = 7 → duty = 2047; volume = 0 → duty = 255; wave = 0x010, volume = 0 → duty = 1 (one high clock per period).
- Sampling boundary: wave = 0x400 latched, change wave to 0xC00 at cnt = 100 → rest of period still 1024 high. Next period 3072 high; duty updates only in the sample_tick cycle.
- Enable gating: drop en at cnt = 500 of a wave = 0x800 period → pwm_out = 0 next edge, duty holds 0x800. Reassert en → sample_tick on first enabled edge, full 2048-high period follows.

Source files
------------

// File: rtl/pwm_dac.sv
// Volume-scaled PWM output stage: latches a scaled sample at each period wrap
// and drives a registered PWM bit plus a one-cycle sample strobe.
module pwm_dac #(
    parameter int WIDTH = 12,
    parameter int VOL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] wave,
    input  logic [VOL_W-1:0] volume,
    output logic             pwm_out,
    output logic             sample_tick,
    output logic [WIDTH-1:0] duty
);

    localparam int PROD_W = WIDTH + VOL_W + 1;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             tick_q, tick_d;

    logic [VOL_W:0]    vol_plus;
    logic [PROD_W-1:0] product;
    logic [WIDTH-1:0]  scaled;
    logic [WIDTH-1:0]  cnt_inc;
    logic              unused_product_bits;

    // Product never exceeds WIDTH+VOL_W bits, so the top bit and the shifted-out
    // fraction are dropped (truncation, no rounding).
    assign vol_plus            = {1'b0, volume} + (VOL_W + 1)'(1);
    assign product             = PROD_W'(wave) * PROD_W'(vol_plus);
    assign scaled              = product[WIDTH+VOL_W-1:VOL_W];
    assign unused_product_bits = ^{product[PROD_W-1], product[VOL_W-1:0]};
    assign cnt_inc             = cnt_q + WIDTH'(1);

    // NOTE: every always_comb output gets a hold default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d  = cnt_q;
        duty_d = duty_q;
        pwm_d  = pwm_q;
        tick_d = tick_q;
        if (!en) begin
            cnt_d  = CNT_MAX;
            pwm_d  = 1'b0;
            tick_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            duty_d = scaled;
            tick_d = 1'b1;
            pwm_d  = (scaled != '0);
        end else begin
            // Compare against the count of the cycle being entered so pwm_out is
            // high for exactly duty clocks, starting in the tick cycle.
            cnt_d  = cnt_inc;
            tick_d = 1'b0;
            pwm_d  = (cnt_inc < duty_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= CNT_MAX;
            duty_q <= '0;
            pwm_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
            tick_q <= tick_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign sample_tick = tick_q;
    assign duty        = duty_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Directed self-checking bench for pwm_dac: reset, duty scaling, period timing,
// sampling boundary and enable gating.
module tb_pwm_dac;

    localparam int WIDTH  = 12;
    localparam int VOL_W  = 4;
    localparam int PERIOD = 1 << WIDTH;
    localparam int BOUND  = PERIOD + 64;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] wave;
    logic [VOL_W-1:0] volume;
    logic             pwm_out;
    logic             sample_tick;
    logic [WIDTH-1:0] duty;

    int checks;
    int errors;

    pwm_dac #(.WIDTH(WIDTH), .VOL_W(VOL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wave        (wave),
        .volume      (volume),
        .pwm_out     (pwm_out),
        .sample_tick (sample_tick),
        .duty        (duty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starting in a tick cycle, count pwm highs and cycles until the next tick.
    // Also flags any tick immediately followed by another tick.
    task automatic run_period(output int high_cnt, output int len, output bit dbl_tick);
        high_cnt = 0;
        len      = 0;
        dbl_tick = 1'b0;
        do begin
            if (pwm_out) high_cnt++;
            len++;
            step();
            if (len == 1 && sample_tick) dbl_tick = 1'b1;
        end while (!sample_tick && len < BOUND);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        en     = 1'b0;
        wave   = '0;
        volume = '0;
        #1;
        checks++;
        if ({pwm_out, sample_tick, duty} !== {1'b0, 1'b0, 12'h000}) begin
            errors++;
            $display("FAIL reset_init: pwm=%b tick=%b duty=%h, want 0 0 000", pwm_out, sample_tick, duty);
        end
        @(negedge clk);
        rst    = 1'b0;
        en     = 1'b1;
        wave   = 12'h300;
        volume = 4'd15;
        step();
        checks++;
        if (sample_tick !== 1'b1 || duty !== 12'h300) begin
            errors++;
            $display("FAIL reset_first_run: tick=%b duty=%h, want 1 300", sample_tick, duty);
        end
        repeat (50) step();
        // Assert reset between edges: outputs must clear with no clock.
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pwm_out, sample_tick, duty} !== {1'b0, 1'b0, 12'h000}) begin
            errors++;
            $display("FAIL reset_async: pwm=%b tick=%b duty=%h, want 0 0 000", pwm_out, sample_tick, duty);
        end
        repeat (3) step();
        wave   = 12'h800;
        volume = 4'd15;
        en     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++;
        if ({sample_tick, pwm_out, duty} !== {1'b1, 1'b1, 12'h800}) begin
            errors++;
            $display("FAIL reset_release: tick=%b pwm=%b duty=%h, want 1 1 800", sample_tick, pwm_out, duty);
        end
    endtask

    task automatic test_midscale();
        int  hi;
        int  len;
        bit  dbl;
        for (int p = 0; p < 3; p++) begin
            run_period(hi, len, dbl);
            checks++;
            if (hi !== 2048 || len !== PERIOD || dbl) begin
                errors++;
                $display("FAIL midscale_p%0d: high=%0d len=%0d dbl=%b, want 2048 4096 0", p, hi, len, dbl);
            end
        end
    endtask

    task automatic test_extremes();
        int hi;
        int len;
        bit dbl;
        wave = 12'hFFF;
        run_period(hi, len, dbl);
        checks++;
        if (duty !== 12'hFFF) begin
            errors++;
            $display("FAIL full_duty: duty=%h, want fff", duty);
        end
        run_period(hi, len, dbl);
        checks++;
        if (hi !== 4095 || len !== PERIOD) begin
            errors++;
            $display("FAIL full_period: high=%0d len=%0d, want 4095 4096", hi, len);
        end
        wave = 12'h000;
        run_period(hi, len, dbl);
        checks++;
        if (duty !== 12'h000) begin
            errors++;
            $display("FAIL zero_duty: duty=%h, want 000", duty);
        end
        run_period(hi, len, dbl);
        checks++;
        if (hi !== 0 || len !== PERIOD) begin
            errors++;
            $display("FAIL zero_period: high=%0d len=%0d, want 0 4096", hi, len);
        end
    endtask

    task automatic test_scaling();
        int hi;
        int len;
        bit dbl;
        wave   = 12'hFFF;
        volume = 4'd7;
        run_period(hi, len, dbl);
        checks++;
        if (duty !== 12'd2047) begin
            errors++;
            $display("FAIL scale_v7: duty=%0d, want 2047", duty);
        end
        volume = 4'd0;
        run_period(hi, len, dbl);
        checks++;
        if (duty !== 12'd255) begin
            errors++;
            $display("FAIL scale_v0: duty=%0d, want 255", duty);
        end
        wave = 12'h010;
        run_period(hi, len, dbl);
        checks++;
        if (duty !== 12'd1) begin
            errors++;
            $display("FAIL scale_small: duty=%0d, want 1", duty);
        end
        run_period(hi, len, dbl);
        checks++;
        if (hi !== 1 || len !== PERIOD) begin
            errors++;
            $display("FAIL scale_small_period: high=%0d len=%0d, want 1 4096", hi, len);
        end
    endtask

    task automatic test_sampling_boundary();
        int hi;
        int len;
        bit dbl;
        wave   = 12'h400;
        volume = 4'd15;
        run_period(hi, len, dbl);
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_out) hi++;
            if (i == 100) wave = 12'hC00;
            if (i == PERIOD - 1) begin
                checks++;
                if (duty !== 12'h400) begin
                    errors++;
                    $display("FAIL sample_hold: duty=%h, want 400", duty);
                end
            end
            step();
        end
        checks++;
        if (hi !== 1024 || sample_tick !== 1'b1 || duty !== 12'hC00) begin
            errors++;
            $display("FAIL sample_change: high=%0d tick=%b duty=%h, want 1024 1 c00", hi, sample_tick, duty);
        end
        run_period(hi, len, dbl);
        checks++;
        if (hi !== 3072 || len !== PERIOD) begin
            errors++;
            $display("FAIL sample_next: high=%0d len=%0d, want 3072 4096", hi, len);
        end
    endtask

    task automatic test_enable();
        int hi;
        int len;
        bit dbl;
        wave = 12'h800;
        run_period(hi, len, dbl);
        repeat (500) step();
        checks++;
        if (pwm_out !== 1'b1) begin
            errors++;
            $display("FAIL en_pre: pwm=%b, want 1", pwm_out);
        end
        en = 1'b0;
        step();
        checks++;
        if ({pwm_out, sample_tick, duty} !== {1'b0, 1'b0, 12'h800}) begin
            errors++;
            $display("FAIL en_drop: pwm=%b tick=%b duty=%h, want 0 0 800", pwm_out, sample_tick, duty);
        end
        repeat (20) step();
        checks++;
        if ({pwm_out, sample_tick, duty} !== {1'b0, 1'b0, 12'h800}) begin
            errors++;
            $display("FAIL en_parked: pwm=%b tick=%b duty=%h, want 0 0 800", pwm_out, sample_tick, duty);
        end
        en = 1'b1;
        step();
        checks++;
        if ({sample_tick, pwm_out, duty} !== {1'b1, 1'b1, 12'h800}) begin
            errors++;
            $display("FAIL en_resume: tick=%b pwm=%b duty=%h, want 1 1 800", sample_tick, pwm_out, duty);
        end
        run_period(hi, len, dbl);
        checks++;
        if (hi !== 2048 || len !== PERIOD || dbl) begin
            errors++;
            $display("FAIL en_period: high=%0d len=%0d dbl=%b, want 2048 4096 0", hi, len, dbl);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_midscale();
        test_extremes();
        test_scaling();
        test_sampling_boundary();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
